// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO; optional Level port via UART_TX_LEVEL_EN
module uart_tx_fifo #(
    parameter int C_SYSTEM_FREQ = 50_000_000,
    parameter int C_BAUDRATE    = 115_200,
    parameter int C_DATA_BITS   = 8,
    parameter int C_USE_PARITY  = 0,
    parameter int C_ODD_PARITY  = 0,
    parameter int C_STOP_BITS   = 1,
    parameter int C_FIFO_DEPTH  = 16
) (
    input  logic                           Clk,
    input  logic                           Resetn,
    input  logic [C_DATA_BITS-1:0]         TX_data,
    input  logic                           wr_uart_en,
    input  logic                           Enable_tx,
    output logic                           Full,
    output logic                           Empty,
    output logic                           Busy,
    output logic                           TX
`ifdef UART_TX_LEVEL_EN
    ,
    output logic [$clog2(C_FIFO_DEPTH):0]  Level
`endif
);

    localparam int DIV = C_SYSTEM_FREQ / C_BAUDRATE;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(C_FIFO_DEPTH);
    localparam int BW  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [C_DATA_BITS-1:0] mem [C_FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            count;
    logic [CW-1:0]          baud_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [C_DATA_BITS-1:0] shift;
    logic                   par_bit;
    logic                   baud_last;
    logic                   frame_end;
    logic                   push;
    logic                   pop;

    assign Full      = (count == (AW+1)'(C_FIFO_DEPTH));
    assign Empty     = (count == '0);
    assign Busy      = (state != S_IDLE);
    assign baud_last = (baud_cnt == CW'(DIV - 1));
    assign frame_end = (state == S_STOP) && baud_last && (bit_cnt == BW'(C_STOP_BITS - 1));
    assign push      = wr_uart_en && !Full;
    // A new frame may start from IDLE or on the final stop-bit cycle, giving back-to-back frames.
    assign pop       = Enable_tx && !Empty && ((state == S_IDLE) || frame_end);

`ifdef UART_TX_LEVEL_EN
    assign Level = count;
`endif

    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= TX_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            TX       <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase

            if (pop) begin
                shift    <= mem[rd_ptr];
                par_bit  <= (^mem[rd_ptr]) ^ (C_ODD_PARITY != 0);
                baud_cnt <= '0;
                bit_cnt  <= '0;
                state    <= S_START;
                TX       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        TX <= 1'b1;
                    end
                    S_START: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            state    <= S_DATA;
                            TX       <= shift[0];
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            if (bit_cnt == BW'(C_DATA_BITS - 1)) begin
                                bit_cnt <= '0;
                                if (C_USE_PARITY != 0) begin
                                    state <= S_PARITY;
                                    TX    <= par_bit;
                                end else begin
                                    state <= S_STOP;
                                    TX    <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                                shift   <= shift >> 1;
                                TX      <= shift[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (baud_last) begin
                            baud_cnt <= '0;
                            state    <= S_STOP;
                            TX       <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    S_STOP: begin
                        TX <= 1'b1;
                        if (baud_last) begin
                            baud_cnt <= '0;
                            if (bit_cnt == BW'(C_STOP_BITS - 1)) begin
                                bit_cnt <= '0;
                                state   <= S_IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            baud_cnt <= baud_cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        TX    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo (frame-level model plus directed vectors)
module tb_uart_tx_fifo;

    localparam int DIV   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic       Clk = 1'b0;
    logic       Resetn = 1'b0;
    logic [7:0] TX_data = '0;
    logic       wr_uart_en = 1'b0;
    logic       Enable_tx = 1'b0;
    logic       Full, Empty, Busy, TX;

    logic [7:0] p_data = '0;
    logic       pe_wr = 1'b0, po_wr = 1'b0;
    logic       pe_full, pe_empty, pe_busy, pe_tx;
    logic       po_full, po_empty, po_busy, po_tx;

`ifdef UART_TX_LEVEL_EN
    logic [2:0] Level, pe_level, po_level;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    int busy_cyc = 0;
    int sel      = 0;

    always #5 Clk = ~Clk;

    uart_tx_fifo #(.C_SYSTEM_FREQ(16), .C_BAUDRATE(1), .C_DATA_BITS(8), .C_USE_PARITY(0),
                   .C_ODD_PARITY(0), .C_STOP_BITS(1), .C_FIFO_DEPTH(DEPTH)) u_dut (
        .Clk(Clk), .Resetn(Resetn), .TX_data(TX_data), .wr_uart_en(wr_uart_en),
        .Enable_tx(Enable_tx), .Full(Full), .Empty(Empty), .Busy(Busy), .TX(TX)
`ifdef UART_TX_LEVEL_EN
        , .Level(Level)
`endif
    );

    uart_tx_fifo #(.C_SYSTEM_FREQ(16), .C_BAUDRATE(1), .C_DATA_BITS(8), .C_USE_PARITY(1),
                   .C_ODD_PARITY(0), .C_STOP_BITS(1), .C_FIFO_DEPTH(DEPTH)) u_pe (
        .Clk(Clk), .Resetn(Resetn), .TX_data(p_data), .wr_uart_en(pe_wr),
        .Enable_tx(1'b1), .Full(pe_full), .Empty(pe_empty), .Busy(pe_busy), .TX(pe_tx)
`ifdef UART_TX_LEVEL_EN
        , .Level(pe_level)
`endif
    );

    uart_tx_fifo #(.C_SYSTEM_FREQ(16), .C_BAUDRATE(1), .C_DATA_BITS(8), .C_USE_PARITY(1),
                   .C_ODD_PARITY(1), .C_STOP_BITS(1), .C_FIFO_DEPTH(DEPTH)) u_po (
        .Clk(Clk), .Resetn(Resetn), .TX_data(p_data), .wr_uart_en(po_wr),
        .Enable_tx(1'b1), .Full(po_full), .Empty(po_empty), .Busy(po_busy), .TX(po_tx)
`ifdef UART_TX_LEVEL_EN
        , .Level(po_level)
`endif
    );

    // Frame-level model of the main instance: a word queue plus a position inside the current frame.
    int         mq[$];
    bit         m_busy = 0;
    int         m_t = 0;
    logic [9:0] m_bits = '1;
    bit         m_start;
    int         m_sz;
    int         m_w;

    always @(posedge Clk) begin
        if (!Resetn) begin
            mq.delete();
            m_busy = 0;
            m_t    = 0;
        end else begin
            m_sz    = mq.size();
            m_start = 0;
            if (m_busy) begin
                if (m_t == FRAME - 1) begin
                    m_busy = 0;
                    if (Enable_tx && m_sz > 0) m_start = 1;
                end else begin
                    m_t++;
                end
            end else if (Enable_tx && m_sz > 0) begin
                m_start = 1;
            end
            if (m_start) begin
                m_w    = mq.pop_front();
                m_bits = {1'b1, m_w[7:0], 1'b0};
                m_busy = 1;
                m_t    = 0;
            end
            if (wr_uart_en && m_sz < DEPTH) mq.push_back(int'(TX_data));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (Busy) busy_cyc++;
        if (chk_en) begin
            chk("model_tx",    int'(TX),    m_busy ? int'(m_bits[m_t / DIV]) : 1);
            chk("model_busy",  int'(Busy),  int'(m_busy));
            chk("model_empty", int'(Empty), int'(mq.size() == 0));
            chk("model_full",  int'(Full),  int'(mq.size() == DEPTH));
`ifdef UART_TX_LEVEL_EN
            chk("model_level", int'(Level), mq.size());
`endif
        end
    end

    function automatic logic tx_of(input int s);
        return (s == 0) ? TX : (s == 1) ? pe_tx : po_tx;
    endfunction

    // Starts on the first cycle of a start bit, samples each bit mid-cell and
    // returns on the first cycle of the bit-time after the last one.
    task automatic cap(input int nb, output logic [10:0] bits);
        bits = '0;
        for (int k = 0; k < nb; k++) begin
            repeat (8) @(negedge Clk);
            bits[k] = tx_of(sel);
            repeat (8) @(negedge Clk);
        end
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge Clk);
        wr_uart_en = 1'b1;
        TX_data    = d;
        @(negedge Clk);
        wr_uart_en = 1'b0;
    endtask

    logic [10:0] fb;
    int          b0;
    int          low_cnt;

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset_tx",    int'(TX),    1);
        chk("reset_busy",  int'(Busy),  0);
        chk("reset_empty", int'(Empty), 1);
        chk("reset_full",  int'(Full),  0);
        Resetn = 1'b1;
        chk_en = 1;
        @(negedge Clk);

        // Single frame 0xA5.
        Enable_tx = 1'b1;
        b0 = busy_cyc;
        push(8'hA5);
        @(negedge Clk);
        chk("t1_start_latency", int'(TX), 0);
        sel = 0;
        cap(10, fb);
        chk("t1_frame_a5", int'(fb[9:0]), int'(10'b1101001010));
        repeat (20) @(negedge Clk);
        chk("t1_busy_cycles", busy_cyc - b0, 160);

        // Overflow: 5 pushes into depth 4, then drain.
        Enable_tx = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge Clk);
            wr_uart_en = 1'b1;
            TX_data    = 8'(i);
        end
        @(negedge Clk);
        wr_uart_en = 1'b0;
        chk("t2_full", int'(Full), 1);
        Enable_tx = 1'b1;
        @(negedge Clk);
        for (int i = 1; i <= 4; i++) begin
            cap(10, fb);
            chk($sformatf("t2_frame_%0d", i), int'(fb[9:0]), int'({1'b1, 8'(i), 1'b0}));
        end
        repeat (5) @(negedge Clk);
        chk("t2_empty_end", int'(Empty), 1);
        chk("t2_idle_end",  int'(Busy),  0);

        // Back-to-back frames with no idle gap.
        b0 = busy_cyc;
        @(negedge Clk);
        wr_uart_en = 1'b1;
        TX_data    = 8'h11;
        @(negedge Clk);
        TX_data    = 8'h22;
        @(negedge Clk);
        wr_uart_en = 1'b0;
        cap(10, fb);
        chk("t3_frame_11", int'(fb[9:0]), int'({1'b1, 8'h11, 1'b0}));
        chk("t3_no_gap", int'(TX), 0);
        cap(10, fb);
        chk("t3_frame_22", int'(fb[9:0]), int'({1'b1, 8'h22, 1'b0}));
        repeat (10) @(negedge Clk);
        chk("t3_busy_cycles", busy_cyc - b0, 320);

        // Parity: 0x07 even -> 1, odd -> 0; 11 bit-times.
        p_data = 8'h07;
        @(negedge Clk);
        pe_wr = 1'b1;
        @(negedge Clk);
        pe_wr = 1'b0;
        @(negedge Clk);
        sel = 1;
        cap(11, fb);
        chk("t4_even_frame", int'(fb), int'({1'b1, 1'b1, 8'h07, 1'b0}));
        chk("t4_even_len", int'(pe_busy), 0);
        @(negedge Clk);
        po_wr = 1'b1;
        @(negedge Clk);
        po_wr = 1'b0;
        @(negedge Clk);
        sel = 2;
        cap(11, fb);
        chk("t4_odd_frame", int'(fb), int'({1'b1, 1'b0, 8'h07, 1'b0}));
        chk("t4_odd_len", int'(po_busy), 0);

        // Level tracking, then reset during the third data bit with two words queued.
        Enable_tx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(8'hC0 + 8'(i));
`ifdef UART_TX_LEVEL_EN
            chk($sformatf("t6_level_%0d", i + 1), int'(Level), i + 1);
`endif
        end
        Enable_tx = 1'b1;
        @(negedge Clk);
`ifdef UART_TX_LEVEL_EN
        chk("t6_level_after_pop", int'(Level), 2);
`endif
        chk("t5_start", int'(TX), 0);
        repeat (56) @(negedge Clk);
        Resetn = 1'b0;
        @(negedge Clk);
        Resetn = 1'b1;
        chk("t5_tx_after_reset",    int'(TX),    1);
        chk("t5_busy_after_reset",  int'(Busy),  0);
        chk("t5_empty_after_reset", int'(Empty), 1);
        low_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clk);
            if (TX == 1'b0) low_cnt++;
        end
        chk("t5_no_more_frames", low_cnt, 0);

        chk_en = 0;
        @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
